// File: rtl/decrypt_req_framer.sv
// decrypt_req_framer: prepends a registered metadata header beat to each packet bound for the decrypt engine
module decrypt_req_framer #(
  parameter int DATA_W = 512,
  parameter int META_W = 272
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [META_W-1:0]   meta_tdata,
  input  logic                meta_tvalid,
  output logic                meta_tready,
  input  logic [DATA_W-1:0]   pkt_tdata,
  input  logic [DATA_W/8-1:0] pkt_tkeep,
  input  logic                pkt_tlast,
  input  logic                pkt_tvalid,
  output logic                pkt_tready,
  output logic [DATA_W-1:0]   out_tdata,
  output logic [DATA_W/8-1:0] out_tkeep,
  output logic                out_tlast,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic [15:0]         len_bytes,
  output logic                len_valid,
  output logic [31:0]         frame_cnt
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int PC_W = $clog2(KEEP_W + 1);
  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;
  state_t state_q, state_d;
  logic [META_W-1:0] meta_q, meta_d;
  logic [15:0] acc_q, acc_d, len_bytes_q, len_bytes_d;
  logic len_valid_q, len_valid_d, run_q;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [PC_W-1:0] pc;
  logic [16:0] sum;
  logic meta_xfer, out_xfer, body_xfer, done;
  always_comb begin
    pc = '0;
    for (int i = 0; i < KEEP_W; i++) pc = pc + PC_W'(pkt_tkeep[i]);
  end
  always_comb begin
    meta_tready = state_q == IDLE && run_q;
    pkt_tready = state_q == BODY && out_tready;
    out_tvalid = state_q == HDR || (state_q == BODY && pkt_tvalid);
    out_tdata = state_q == HDR ? DATA_W'(meta_q) : state_q == BODY ? pkt_tdata : '0;
    out_tkeep = state_q == HDR ? KEEP_W'({(META_W/8){1'b1}}) : state_q == BODY ? pkt_tkeep : '0;
    out_tlast = state_q == BODY && pkt_tlast;
    len_bytes = len_bytes_q;
    len_valid = len_valid_q;
    frame_cnt = frame_cnt_q;
    meta_xfer = meta_tvalid && meta_tready;
    out_xfer = out_tvalid && out_tready;
    body_xfer = state_q == BODY && out_xfer;
    done = body_xfer && pkt_tlast;
    state_d = state_q == IDLE ? (meta_xfer ? HDR : IDLE) :
              state_q == HDR ? (out_xfer ? BODY : HDR) :
              (done ? IDLE : BODY);
    meta_d = meta_xfer ? meta_tdata : meta_q;
    sum = {1'b0, acc_q} + 17'(pc);
    acc_d = meta_xfer ? '0 : body_xfer ? (sum[16] ? 16'hFFFF : sum[15:0]) : acc_q;
    len_bytes_d = done ? acc_d : len_bytes_q;
    len_valid_d = done;
    frame_cnt_d = frame_cnt_q + 32'(done);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      meta_q <= '0;
      acc_q <= '0;
      len_bytes_q <= '0;
      len_valid_q <= 1'b0;
      frame_cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q <= meta_d;
      acc_q <= acc_d;
      len_bytes_q <= len_bytes_d;
      len_valid_q <= len_valid_d;
      frame_cnt_q <= frame_cnt_d;
      run_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_decrypt_req_framer.sv
// tb_decrypt_req_framer: randomized frame traffic against a queue-based model of the framed stream
module tb_decrypt_req_framer;
  localparam int DATA_W = 512;
  localparam int META_W = 272;
  localparam int KW = DATA_W / 8;
  localparam logic [KW-1:0] HDR_KEEP = 64'h0000_0003_FFFF_FFFF;
  localparam logic [KW-1:0] ONES = '1;
  typedef logic [DATA_W-1:0] w_t;
  typedef struct {logic [DATA_W-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
  logic clk = 0, rst;
  logic [META_W-1:0] meta_tdata;
  logic meta_tvalid, meta_tready;
  logic [DATA_W-1:0] pkt_tdata, out_tdata;
  logic [KW-1:0] pkt_tkeep, out_tkeep;
  logic pkt_tlast, pkt_tvalid, pkt_tready;
  logic out_tlast, out_tvalid, out_tready;
  logic [15:0] len_bytes;
  logic len_valid;
  logic [31:0] frame_cnt;
  always #5 clk = ~clk;
  decrypt_req_framer dut (
    .clk(clk), .rst(rst),
    .meta_tdata(meta_tdata), .meta_tvalid(meta_tvalid), .meta_tready(meta_tready),
    .pkt_tdata(pkt_tdata), .pkt_tkeep(pkt_tkeep), .pkt_tlast(pkt_tlast),
    .pkt_tvalid(pkt_tvalid), .pkt_tready(pkt_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .len_bytes(len_bytes), .len_valid(len_valid), .frame_cnt(frame_cnt)
  );
  int total = 0, bad = 0, cyc = 0;
  beat_t expq[$], pktq[$];
  logic [META_W-1:0] metaq[$];
  int lenq[$], meta_cycs[$], last_cycs[$];
  bit rdy_pat[$];
  int v_pct = 100, r_pct = 100, ph = 0, pend_len = 0, hx_cyc = 0, d1_cyc = 0, nout = 0;
  bit meta_en = 1, rst_v = 0, mv = 0, pv = 0, pend = 0, hold_prev = 0, mx_prev = 0, first_d = 0;
  logic [15:0] exp_len = 0;
  logic [31:0] exp_cnt = 0;
  logic [DATA_W-1:0] pd;
  logic [KW-1:0] pk;
  logic pl;
  task automatic chk(input string tag, input w_t got, input w_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic w_t rnd();
    w_t r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32+:32] = $urandom;
    return r;
  endfunction
  function automatic logic [KW-1:0] rnd_keep();
    int c, n;
    w_t t;
    c = int'($urandom_range(3));
    n = int'($urandom_range(KW, 1));
    t = rnd();
    return c == 0 ? ONES : c == 1 ? '0 : c == 2 ? (ONES >> (KW - n)) : t[KW-1:0];
  endfunction
  task automatic add_frame(input int nb, input int kind);
    beat_t b;
    w_t t;
    int s = 0;
    t = rnd();
    metaq.push_back(t[META_W-1:0]);
    b.d = w_t'(t[META_W-1:0]);
    b.k = HDR_KEEP;
    b.l = 0;
    expq.push_back(b);
    for (int i = 0; i < nb; i++) begin
      b.d = rnd();
      b.l = i == nb - 1;
      b.k = kind == 1 ? ONES : kind == 2 ? (i == nb - 1 ? KW'(16'hFFFF) : ONES) :
            (kind == 3 && i == 1) ? '0 : rnd_keep();
      s += $countones(b.k);
      pktq.push_back(b);
      expq.push_back(b);
    end
    lenq.push_back(s > 65535 ? 65535 : s);
  endtask
  task automatic step();
    beat_t e;
    w_t t;
    bit mx, px, ox;
    int nph;
    @(negedge clk);
    rst = rst_v;
    if (!mv && metaq.size() > 0 && meta_en && int'($urandom_range(99)) < v_pct) mv = 1;
    t = rnd();
    meta_tvalid = mv;
    if (mv) meta_tdata = metaq[0];
    else meta_tdata = t[META_W-1:0];
    if (!pv && pktq.size() > 0 && int'($urandom_range(99)) < v_pct) pv = 1;
    t = rnd();
    pkt_tvalid = pv;
    if (pv) begin
      pkt_tdata = pktq[0].d;
      pkt_tkeep = pktq[0].k;
      pkt_tlast = pktq[0].l;
    end else begin
      pkt_tdata = rnd();
      pkt_tkeep = t[KW-1:0];
      pkt_tlast = t[KW];
    end
    if (rdy_pat.size() > 0) out_tready = rdy_pat.pop_front();
    else out_tready = int'($urandom_range(99)) < r_pct;
    #1;
    cyc++;
    if (rst) begin
      if (pend) begin
        exp_len = 16'(pend_len);
        exp_cnt = exp_cnt + 1;
      end
      chk("len_valid", w_t'(len_valid), w_t'(pend));
      chk("len_bytes", w_t'(len_bytes), w_t'(exp_len));
      chk("frame_cnt", w_t'(frame_cnt), w_t'(exp_cnt));
      pend = 0;
      if (hold_prev) begin
        chk("hold_valid", w_t'(out_tvalid), w_t'(1));
        chk("hold_data", out_tdata, pd);
        chk("hold_keep", w_t'(out_tkeep), w_t'(pk));
        chk("hold_last", w_t'(out_tlast), w_t'(pl));
      end
      if (mx_prev) chk("hdr_lat", w_t'(out_tvalid), w_t'(1));
      if (ph == 2) begin
        chk("pass_valid", w_t'(out_tvalid), w_t'(pkt_tvalid));
        chk("pass_ready", w_t'(pkt_tready), w_t'(out_tready));
      end else chk("pkt_bp", w_t'(pkt_tready), '0);
      if (ph != 0) chk("meta_bp", w_t'(meta_tready), '0);
      else chk("idle_valid", w_t'(out_tvalid), '0);
      mx = meta_tvalid && meta_tready;
      px = pkt_tvalid && pkt_tready;
      ox = out_tvalid && out_tready;
      nph = ph;
      if (mx && metaq.size() > 0) begin
        void'(metaq.pop_front());
        mv = 0;
        meta_cycs.push_back(cyc);
        if (ph == 0) nph = 1;
      end
      if (px && pktq.size() > 0) begin
        void'(pktq.pop_front());
        pv = 0;
      end
      if (ox) begin
        nout++;
        if (expq.size() == 0) chk("extra_beat", w_t'(out_tvalid), '0);
        else begin
          e = expq.pop_front();
          chk("out_data", out_tdata, e.d);
          chk("out_keep", w_t'(out_tkeep), w_t'(e.k));
          chk("out_last", w_t'(out_tlast), w_t'(e.l));
        end
        if (ph == 1) begin
          nph = 2;
          hx_cyc = cyc;
          first_d = 1;
        end else if (ph == 2) begin
          if (first_d) begin
            d1_cyc = cyc;
            first_d = 0;
          end
          if (out_tlast) begin
            nph = 0;
            pend = 1;
            pend_len = lenq.size() > 0 ? lenq.pop_front() : 0;
            last_cycs.push_back(cyc);
          end
        end
      end
      ph = nph;
      mx_prev = mx;
      hold_prev = out_tvalid && !out_tready;
      pd = out_tdata;
      pk = out_tkeep;
      pl = out_tlast;
    end
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while ((expq.size() > 0 || pend) && n < budget) begin
      step();
      n++;
    end
    chk("drain", w_t'(expq.size()), '0);
  endtask
  task automatic do_reset();
    metaq.delete();
    pktq.delete();
    expq.delete();
    lenq.delete();
    rdy_pat.delete();
    mv = 0;
    pv = 0;
    ph = 0;
    pend = 0;
    hold_prev = 0;
    mx_prev = 0;
    exp_len = 0;
    exp_cnt = 0;
    rst_v = 0;
    repeat (3) step();
    rst_v = 1;
    step();
    chk("rst_out_valid", w_t'(out_tvalid), '0);
    chk("rst_out_data", out_tdata, '0);
    chk("rst_out_keep", w_t'(out_tkeep), '0);
    chk("rst_out_last", w_t'(out_tlast), '0);
    chk("rst_meta_ready", w_t'(meta_tready), '0);
    chk("rst_pkt_ready", w_t'(pkt_tready), '0);
    chk("rst_len_bytes", w_t'(len_bytes), '0);
    chk("rst_len_valid", w_t'(len_valid), '0);
    chk("rst_frame_cnt", w_t'(frame_cnt), '0);
    step();
    chk("meta_ready_rise", w_t'(meta_tready), w_t'(1));
  endtask
  initial begin
    int n, g;
    logic [31:0] e0;
    rst = 0;
    meta_tdata = '0;
    meta_tvalid = 0;
    pkt_tdata = '0;
    pkt_tkeep = '0;
    pkt_tlast = 0;
    pkt_tvalid = 0;
    out_tready = 0;
    do_reset();
    nout = 0;
    add_frame(4, 2);
    drain(100);
    chk("single_beats", w_t'(nout), w_t'(5));
    chk("single_len", w_t'(len_bytes), w_t'(208));
    chk("single_cnt", w_t'(frame_cnt), w_t'(1));
    rdy_pat = '{1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    add_frame(6, 1);
    drain(100);
    meta_en = 0;
    add_frame(2, 1);
    repeat (5) step();
    meta_en = 1;
    drain(100);
    chk("order_lat", w_t'(d1_cyc - hx_cyc), w_t'(1));
    meta_cycs.delete();
    last_cycs.delete();
    e0 = exp_cnt;
    add_frame(1, 0);
    add_frame(1, 0);
    drain(100);
    g = (meta_cycs.size() >= 2 && last_cycs.size() >= 1) ? meta_cycs[1] - last_cycs[0] : -1;
    chk("b2b_gap", w_t'(g), w_t'(1));
    chk("b2b_cnt", w_t'(frame_cnt), w_t'(e0 + 2));
    v_pct = 70;
    r_pct = 70;
    repeat (20) add_frame(int'($urandom_range(6, 1)), 0);
    drain(3000);
    v_pct = 100;
    r_pct = 100;
    add_frame(1100, 1);
    drain(1500);
    chk("sat_len", w_t'(len_bytes), w_t'(16'hFFFF));
    add_frame(3, 3);
    drain(100);
    chk("zero_keep_len", w_t'(len_bytes), w_t'(exp_len));
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.frame_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    add_frame(2, 0);
    drain(100);
    chk("wrap_cnt", w_t'(frame_cnt), '0);
    nout = 0;
    add_frame(4, 1);
    n = 0;
    while (nout < 2 && n < 50) begin
      step();
      n++;
    end
    chk("mid_progress", w_t'(nout), w_t'(2));
    do_reset();
    add_frame(2, 0);
    drain(100);
    chk("after_rst_cnt", w_t'(frame_cnt), w_t'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decrypt_req_framer.md
DECRYPT_REQ_FRAMER -- requirements
Module: decrypt_req_framer

Interface
REQ-001 Parameter: DATA_W, 512, packet/output data width in bits.
REQ-002 Parameter: META_W, 272, decrypt-request metadata struct width in bits; SHALL be at most DATA_W and a multiple of 8.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-low reset.
REQ-005 Port: meta_tdata  in  META_W  decrypt-request struct.
REQ-006 Port: meta_tvalid  in  1; meta_tready  out  1.
REQ-007 Port: pkt_tdata  in  DATA_W; pkt_tkeep  in  DATA_W/8; pkt_tlast  in  1; pkt_tvalid  in  1; pkt_tready  out  1; packet buffer stream.
REQ-008 Port: out_tdata  out  DATA_W; out_tkeep  out  DATA_W/8; out_tlast  out  1; out_tvalid  out  1; out_tready  in  1; framed stream to the decrypt engine.
REQ-009 Port: len_bytes  out  16  payload byte count of the last completed frame; len_valid  out  1  one-cycle pulse.
REQ-010 Port: frame_cnt  out  32  completed frames since reset.

Function
REQ-011 A transfer occurs on any stream when tvalid and tready are both high on a rising edge.
REQ-012 FSM states: IDLE, HDR and BODY.
REQ-013 IDLE: meta_tready=1, pkt_tready=0, out_tvalid=0; on a meta transfer, register meta_tdata and go to HDR next cycle.
REQ-014 HDR: meta_tready=0 and pkt_tready=0; out_tvalid=1 with registered outputs.
REQ-015 HDR output beat: out_tdata = zero-extended meta in bits [META_W-1:0]; out_tkeep = low META_W/8 bits set (34 bytes, 64'h0000_0003_FFFF_FFFF at defaults); out_tlast=0.
REQ-016 HDR outputs SHALL hold stable while out_tready=0; on an out transfer, go to BODY.
REQ-017 BODY: zero-latency pass-through with out_tdata/tkeep/tlast/tvalid = pkt_*, pkt_tready = out_tready, and meta_tready=0.
REQ-018 BODY: on an out transfer with pkt_tlast=1, go to IDLE next cycle.
REQ-019 Byte accumulator: cleared on entry to HDR; on each BODY transfer, add popcount(pkt_tkeep); saturate at 16'hFFFF.
REQ-020 Frame completion: in the cycle after the BODY tlast transfer, len_bytes = final accumulator value (including the last beat), len_valid=1 for exactly one cycle, and frame_cnt increments.
REQ-021 len_bytes SHALL hold its value until the next completion.
REQ-022 frame_cnt wraps from 32'hFFFF_FFFF to 0.
REQ-023 A BODY beat with tkeep=0 SHALL be forwarded and add 0 bytes.
REQ-024 A one-beat packet (tlast on the first BODY beat) is legal.
REQ-025 Minimum spacing: a meta accept in IDLE the cycle after tlast puts the next header valid 2 cycles after the tlast transfer.
REQ-026 Latency: meta transfer at cycle N gives header out_tvalid at N+1.
REQ-027 pkt_tvalid in IDLE or HDR and meta_tvalid in HDR or BODY SHALL be back-pressured, never dropped.
REQ-028 Header data SHALL be unaffected by meta_tdata changes after capture.

Reset
REQ-029 While rst=0 at a clock edge, the block SHALL enter the following state on the next cycle:
- FSM=IDLE.
- out_tvalid=0, out_tdata=0, out_tkeep=0, out_tlast=0.
- meta_tready=0, pkt_tready=0.
- len_bytes=0, len_valid=0, frame_cnt=0; accumulator cleared.
REQ-030 Reset asserted mid-frame (HDR or BODY) SHALL abandon the frame with no len_valid pulse and no frame_cnt increment. The upstream remainder is the source's responsibility.
REQ-031 meta_tready SHALL rise the first cycle after rst returns high.

Verification
REQ-032 Single frame: one meta, pkt of 3 full beats (tkeep all-ones) plus a last beat with tkeep=64'h0000_0000_0000_FFFF, out_tready=1 -> 5 out beats (header with 34-byte tkeep, then 4 data beats in order); len_bytes=208; len_valid single pulse; frame_cnt=1.
REQ-033 Back-pressure: out_tready low 4 cycles during HDR and 3 cycles mid-BODY -> header stable throughout, no duplicated or lost beats, pkt_tready low exactly when out_tready is low in BODY.
REQ-034 Ordering: pkt_tvalid high before meta -> pkt_tready=0 until the header transfers, then the first pkt beat appears on the next cycle's BODY transfer.
REQ-035 Back-to-back frames: two metas and two 1-beat packets, continuous valids -> beat sequence H,D,H,D; second header 2 cycles after the first tlast; frame_cnt=2.
REQ-036 Edge cases:
- 1100 full beats -> len_bytes saturates at 16'hFFFF.
- Zero-tkeep beat -> forwarded, count unchanged.
- frame_cnt preset via force to 32'hFFFF_FFFF -> wraps to 0.
REQ-037 Reset at the second BODY beat -> outputs zero next cycle, no len_valid pulse, frame_cnt unchanged, then a new frame completes normally.
